// File: rtl/fifo_ptr_pkg.sv
// fifo_ptr_pkg: shared FIFO pointer helpers (Gray conversions, depth) for the write- and read-side controllers
package fifo_ptr_pkg;
  localparam int PTR_MAX = 17;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEPTH = 2 ** DEF_ADDR_WIDTH;
  typedef logic [PTR_MAX-1:0] ptr_t;
  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction
  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b = g;
    for (int i = PTR_MAX - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/gray2bin_conv.sv
// gray2bin_conv: combinational Gray-to-binary converter of parametrised width
module gray2bin_conv import fifo_ptr_pkg::*; #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);
  assign bin = W'(gray2bin(ptr_t'(gray)));
endmodule

// File: rtl/wt_ptr_ctrl.sv
// wt_ptr_ctrl: async-FIFO write pointer controller (Gray pointer, full, level, overflow); WT_AFULL_EN adds wt_afull
module wt_ptr_ctrl import fifo_ptr_pkg::*; #(
  parameter int ADDR_WIDTH = 4
`ifdef WT_AFULL_EN
  , parameter int AF_THRESH = depth_of(ADDR_WIDTH) - 2
`endif
) (
  input  logic                  wt_clk_gen,
  input  logic                  rst_n_wt_gen_in,
  input  logic                  wt_en_gen,
  input  logic [ADDR_WIDTH:0]   rd_gray_sync,
  output logic [ADDR_WIDTH-1:0] wt_addr_gen,
  output logic [ADDR_WIDTH:0]   wt_gray_gen,
  output logic                  wt_accept,
  output logic                  wt_full,
`ifdef WT_AFULL_EN
  output logic                  wt_afull,
`endif
  output logic [ADDR_WIDTH:0]   wt_level,
  output logic                  wt_ovf
);
  localparam int PW = ADDR_WIDTH + 1;
  logic [ADDR_WIDTH:0] wt_bin, next_bin, next_gray, rd_bin, full_gray, next_level;
  logic next_full;
  gray2bin_conv #(.W(PW)) u_rd_conv (.gray(rd_gray_sync), .bin(rd_bin));
  assign wt_accept = wt_en_gen & ~wt_full;
  assign wt_addr_gen = wt_bin[ADDR_WIDTH-1:0];
  // next pointer and the flags it implies against the synchronised read pointer
  always_comb begin
    next_bin = wt_bin + {{ADDR_WIDTH{1'b0}}, wt_accept};
    next_gray = PW'(bin2gray(ptr_t'(next_bin)));
    full_gray = {~rd_gray_sync[ADDR_WIDTH -: 2], rd_gray_sync[ADDR_WIDTH-2:0]};
    next_full = next_gray == full_gray;
    next_level = next_bin - rd_bin;
  end
  // pointer, Gray image, flags and level all update together so the read side sees a consistent view
  always_ff @(posedge wt_clk_gen or negedge rst_n_wt_gen_in) begin
    if (!rst_n_wt_gen_in) begin
      wt_bin <= '0;
      wt_gray_gen <= '0;
      wt_full <= 1'b0;
      wt_level <= '0;
      wt_ovf <= 1'b0;
`ifdef WT_AFULL_EN
      wt_afull <= 1'b0;
`endif
    end else begin
      wt_bin <= next_bin;
      wt_gray_gen <= next_gray;
      wt_full <= next_full;
      wt_level <= next_level;
      wt_ovf <= wt_ovf | (wt_en_gen & wt_full);
`ifdef WT_AFULL_EN
      wt_afull <= next_level >= PW'(AF_THRESH);
`endif
    end
  end
endmodule

// File: tb/tb_wt_ptr_ctrl.sv
// tb_wt_ptr_ctrl: randomized self-checking bench for wt_ptr_ctrl against an occupancy-counting model
module tb_wt_ptr_ctrl;
  localparam int AW = 4;
  localparam int D = 16;
  localparam int M = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [AW:0] rd_gray = '0;
  logic [AW-1:0] addr;
  logic [AW:0] gray, level;
  logic accept, full, ovf;
`ifdef WT_AFULL_EN
  logic afull;
`endif
  int n_chk = 0;
  int n_fail = 0;
  int m_wb, m_rb, m_level;
  bit m_full, m_afull, m_ovf;

  wt_ptr_ctrl #(
    .ADDR_WIDTH(AW)
`ifdef WT_AFULL_EN
    , .AF_THRESH(14)
`endif
  ) dut (
    .wt_clk_gen(clk),
    .rst_n_wt_gen_in(rst_n),
    .wt_en_gen(en),
    .rd_gray_sync(rd_gray),
    .wt_addr_gen(addr),
    .wt_gray_gen(gray),
    .wt_accept(accept),
    .wt_full(full),
`ifdef WT_AFULL_EN
    .wt_afull(afull),
`endif
    .wt_level(level),
    .wt_ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [AW:0] to_gray(input int b);
    logic [AW:0] v;
    v = b[AW:0];
    return v ^ (v >> 1);
  endfunction

  task automatic model_clear();
    m_wb = 0; m_rb = 0; m_level = 0;
    m_full = 0; m_afull = 0; m_ovf = 0;
  endtask

  task automatic do_reset();
    en = 1'b0;
    rd_gray = '0;
    rst_n = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic cycle(input bit e, input int rb);
    en = e;
    rd_gray = to_gray(rb);
    @(posedge clk);
    if (e && m_full) m_ovf = 1;
    if (e && !m_full) m_wb = (m_wb + 1) % M;
    m_rb = rb % M;
    m_level = (m_wb - m_rb + M) % M;
    m_full = m_level == D;
    m_afull = m_level >= 14;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (addr !== 0 || gray !== 0) begin n_fail++; $display("FAIL reset_ptr: addr=%0d gray=%b want 0/0", addr, gray); end
    n_chk++; if (full !== 0 || level !== 0 || ovf !== 0) begin n_fail++; $display("FAIL reset_flags: full=%b level=%0d ovf=%b want 0", full, level, ovf); end
    repeat (5) cycle(1, 0);
    n_chk++; if (addr !== 4'd5 || level !== 5'd5) begin n_fail++; $display("FAIL pre_reset: addr=%0d level=%0d want 5/5", addr, level); end
    en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (addr !== 0 || gray !== 0 || level !== 0 || full !== 0 || ovf !== 0) begin n_fail++; $display("FAIL async_reset: addr=%0d gray=%b level=%0d want 0", addr, gray, level); end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    en = 1'b1;
    #1;
    n_chk++; if (accept !== 1'b1 || addr !== 0) begin n_fail++; $display("FAIL first_write: accept=%b addr=%0d want 1/0", accept, addr); end
    cycle(1, 0);
    n_chk++; if (addr !== 4'd1 || gray !== to_gray(1)) begin n_fail++; $display("FAIL after_first: addr=%0d gray=%b want 1/%b", addr, gray, to_gray(1)); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      cycle(1, 0);
      if (i == 15) begin
        n_chk++; if (full !== 0 || level !== 5'd15) begin n_fail++; $display("FAIL fill_15: full=%b level=%0d want 0/15", full, level); end
      end
    end
    n_chk++; if (full !== 1'b1 || level !== 5'd16) begin n_fail++; $display("FAIL fill_16: full=%b level=%0d want 1/16", full, level); end
    n_chk++; if (gray !== 5'b11000 || addr !== 0) begin n_fail++; $display("FAIL fill_gray: gray=%b addr=%0d want 11000/0", gray, addr); end
  endtask

  task automatic test_overflow();
    en = 1'b1;
    #1;
    n_chk++; if (accept !== 1'b0) begin n_fail++; $display("FAIL ovf_accept: accept=%b want 0", accept); end
    cycle(1, 0);
    n_chk++; if (gray !== 5'b11000 || addr !== 0 || level !== 5'd16) begin n_fail++; $display("FAIL ovf_hold: gray=%b addr=%0d level=%0d want 11000/0/16", gray, addr, level); end
    n_chk++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: ovf=%b want 1", ovf); end
    repeat (3) cycle(0, 0);
    n_chk++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: ovf=%b want 1", ovf); end
  endtask

  task automatic test_wrap();
    cycle(0, 16);
    n_chk++; if (full !== 0 || level !== 0) begin n_fail++; $display("FAIL wrap_drain: full=%b level=%0d want 0/0", full, level); end
    repeat (3) cycle(1, 16);
    n_chk++; if (addr !== 4'd3 || level !== 5'd3 || full !== 0) begin n_fail++; $display("FAIL wrap: addr=%0d level=%0d full=%b want 3/3/0", addr, level, full); end
    n_chk++; if (gray !== to_gray(19)) begin n_fail++; $display("FAIL wrap_gray: gray=%b want %b", gray, to_gray(19)); end
  endtask

`ifdef WT_AFULL_EN
  task automatic test_afull();
    do_reset();
    for (int i = 1; i <= 14; i++) begin
      cycle(1, 0);
      if (i == 13) begin
        n_chk++; if (afull !== 0) begin n_fail++; $display("FAIL afull_13: afull=%b want 0", afull); end
      end
    end
    n_chk++; if (afull !== 1'b1) begin n_fail++; $display("FAIL afull_14: afull=%b want 1", afull); end
    cycle(0, 1);
    n_chk++; if (afull !== 0 || level !== 5'd13) begin n_fail++; $display("FAIL afull_drop: afull=%b level=%0d want 0/13", afull, level); end
  endtask
`endif

  task automatic test_simultaneous();
    logic [AW:0] g0;
    do_reset();
    repeat (8) cycle(1, 0);
    g0 = gray;
    cycle(1, 1);
    n_chk++; if (level !== 5'd8) begin n_fail++; $display("FAIL simul_level: level=%0d want 8", level); end
    n_chk++; if ($countones(g0 ^ gray) != 1) begin n_fail++; $display("FAIL simul_gray: prev=%b now=%b want one-bit change", g0, gray); end
    cycle(1, 2);
    n_chk++; if (level !== 5'd8 || addr !== 4'd10) begin n_fail++; $display("FAIL simul_level2: level=%0d addr=%0d want 8/10", level, addr); end
  endtask

  task automatic test_random();
    bit e;
    int rb, adv;
    logic [AW:0] g0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      e = $urandom_range(0, 9) < 7;
      adv = (c % 100 < 40) ? 0 : $urandom_range(0, (m_level < 2) ? m_level : 2);
      rb = (m_rb + adv) % M;
      en = e;
      rd_gray = to_gray(rb);
      #1;
      n_chk++; if (accept !== (e && !m_full)) begin n_fail++; $display("FAIL rnd_accept c=%0d: accept=%b want %b", c, accept, e && !m_full); end
      g0 = gray;
      cycle(e, rb);
      n_chk++; if (addr !== 4'(m_wb % D) || gray !== to_gray(m_wb)) begin n_fail++; $display("FAIL rnd_ptr c=%0d: addr=%0d gray=%b want %0d/%b", c, addr, gray, m_wb % D, to_gray(m_wb)); end
      n_chk++; if (level !== 5'(m_level) || full !== m_full || ovf !== m_ovf) begin n_fail++; $display("FAIL rnd_flags c=%0d: level=%0d full=%b ovf=%b want %0d/%b/%b", c, level, full, ovf, m_level, m_full, m_ovf); end
      n_chk++; if ($countones(g0 ^ gray) > 1) begin n_fail++; $display("FAIL rnd_gray_step c=%0d: prev=%b now=%b", c, g0, gray); end
`ifdef WT_AFULL_EN
      n_chk++; if (afull !== m_afull) begin n_fail++; $display("FAIL rnd_afull c=%0d: afull=%b want %b", c, afull, m_afull); end
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_wrap();
`ifdef WT_AFULL_EN
    test_afull();
`endif
    test_simultaneous();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
